// File: rtl/mem_resp_pkg.sv
// Shared types and limits for the memory-side responder.
// The entry type below uses the default widths; instances with other widths supply their own type.
package mem_resp_pkg;

  localparam int unsigned MAX_RD_LAT = 8;
  localparam int unsigned DEF_TAG_W  = 4;
  localparam int unsigned DEF_DATA_W = 32;

  typedef struct packed {
    logic                  we;
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_DATA_W-1:0] rdata;
  } rsp_entry_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO with a separate occupancy count, so full and empty never alias.
// The head output reads as all-zero whenever the FIFO is empty.
module resp_fifo
  import mem_resp_pkg::*;
#(
  parameter type         entry_t = rsp_entry_t,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count != '0) ? store[rd_ptr] : '0;

endmodule

// File: rtl/mem_responder.sv
// Memory-side slave: byte-enabled word array, fixed-latency response pipeline and
// credit-limited request acceptance so that no response is dropped while rsp_ready is low.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_we,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [DATA_W-1:0]   rsp_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  if ((RD_LAT < 1) || (RD_LAT > MAX_RD_LAT)) begin : g_bad_rd_lat
    $error("mem_responder: RD_LAT out of range");
  end

  typedef struct packed {
    logic              we;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] rdata;
  } entry_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              out_of_reset;
  logic              accept;
  logic [RD_LAT-1:0] pipe_v;
  entry_t            pipe_e [RD_LAT];
  entry_t            head;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  occupancy;
  logic              pop;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  // Array storage carries no reset; only lanes with an active enable are written.
  always_ff @(posedge clk) begin
    if (accept && req_we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (req_be[i]) begin
          mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data is taken on the accept edge, before any write on that same edge lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_e[i] <= '0;
      end
    end else begin
      pipe_v[0] <= accept;
      if (accept) begin
        pipe_e[0] <= entry_t'{we: req_we, tag: req_tag,
                              rdata: req_we ? '0 : mem[req_addr]};
      end else begin
        pipe_e[0] <= '0;
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
      end
    end
  end

  assign pop = rsp_valid && rsp_ready;

  resp_fifo #(
    .entry_t (entry_t),
    .DEPTH   (RSP_DEPTH),
    .CNT_W   (CNT_W)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_v[RD_LAT-1]),
    .push_data (pipe_e[RD_LAT-1]),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  // Credit counts everything already promised a FIFO slot, using registered state only.
  always_comb begin
    occupancy = fifo_count;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      occupancy = occupancy + CNT_W'(pipe_v[i]);
    end
  end

  assign req_ready = out_of_reset && (occupancy < CNT_W'(RSP_DEPTH));

  assign rsp_valid = (fifo_count != '0);
  assign rsp_we    = head.we;
  assign rsp_tag   = head.tag;
  assign rsp_rdata = head.rdata;

endmodule
